// File: rtl/jt6295_pkg.sv
// jt6295_pkg: shared constants for the JT6295 CIC decimator.
// Holds default CIC geometry and the internal-width derivation.
package jt6295_pkg;

    localparam int DEF_INW  = 14;
    localparam int DEF_OUTW = 14;
    localparam int DEF_RATE = 4;
    localparam int DEF_M    = 4;
    localparam int DEF_N    = 2;

    // Bit growth of an N-stage CIC is N*log2(R*M) above the input width.
    function automatic int calc_w(int inw, int n, int rate, int m);
        return inw + n * $clog2(rate * m);
    endfunction

    localparam int DEF_CALCW = calc_w(DEF_INW, DEF_N, DEF_RATE, DEF_M);
    localparam int OUT_SHIFT = DEF_CALCW - DEF_OUTW;

endpackage

// File: rtl/jt6295_decim_if.sv
// jt6295_decim_if: sample-stream bundle between a cen4-rate source
// and the decimator (enables, input sample, decimated output + strobe).
interface jt6295_decim_if
    import jt6295_pkg::*;
#(
    parameter int INW  = DEF_INW,
    parameter int OUTW = DEF_OUTW
);
    logic                   cen4;
    logic                   cen;
    logic signed [INW-1:0]  sound_in;
    logic signed [OUTW-1:0] sound_out;
    logic                   sample;

    modport master (
        output cen4, cen, sound_in,
        input  sound_out, sample
    );

    modport slave (
        input  cen4, cen, sound_in,
        output sound_out, sample
    );
endinterface

// File: rtl/jt6295_decim_comb.sv
// jt6295_decim_comb: one CIC comb stage, an M-deep delay line and a
// subtractor, both advancing only on the decimated strobe.
module jt6295_decim_comb
    import jt6295_pkg::*;
#(
    parameter int W = DEF_CALCW,
    parameter int m = DEF_M
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                en,
    input  logic signed [W-1:0] din,
    output logic signed [W-1:0] dout
);
    logic signed [W-1:0] dly [0:m-1];

    // Difference against the input seen m strobes ago; shift the history.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dout <= '0;
            for (int k = 0; k < m; k++) dly[k] <= '0;
        end else if (en) begin
            dout   <= din - dly[m-1];
            dly[0] <= din;
            for (int k = 1; k < m; k++) dly[k] <= dly[k-1];
        end
    end
endmodule

// File: rtl/jt6295_decim.sv
// jt6295_decim: 2-stage CIC decimator, cen4 rate down to cen rate (R=4).
// Macro JT6295_DECIM_ROUND_EN selects round-half-up plus saturation.
module jt6295_decim
    import jt6295_pkg::*;
#(
    parameter int INW  = DEF_INW,
    parameter int OUTW = DEF_OUTW,
    parameter int rate = DEF_RATE,
    parameter int m    = DEF_M,
    parameter int n    = DEF_N
) (
    input  logic          clk,
    input  logic          rst,
    jt6295_decim_if.slave bus
);
    localparam int CALCW = calc_w(INW, n, rate, m);
    localparam int SHIFT = CALCW - OUTW;

    logic signed [CALCW-1:0] i1, i2, x;
    logic [n:0][CALCW-1:0]   chain;
    logic [CALCW-1:0]        c2;
    logic [OUTW-1:0]         out_next;
    logic [OUTW-1:0]         dout;
    logic                    smp;
    logic                    strobe;

    // cen only counts when it lines up with an input sample
    assign strobe = bus.cen & bus.cen4;

    // Integrators run at the input rate; i2 accumulates the old i1.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            i1 <= '0;
            i2 <= '0;
        end else if (bus.cen4) begin
            i1 <= i1 + {{(CALCW-INW){bus.sound_in[INW-1]}}, bus.sound_in};
            i2 <= i2 + i1;
        end
    end

    // Decimation: grab the integrator output on each slow strobe.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) x <= '0;
        else if (strobe) x <= i2;
    end

    assign chain[0] = x;

    for (genvar k = 0; k < n; k++) begin : g_comb
        jt6295_decim_comb #(.W(CALCW), .m(m)) u_comb (
            .clk  (clk),
            .rst  (rst),
            .en   (strobe),
            .din  (chain[k]),
            .dout (chain[k+1])
        );
    end

    assign c2 = chain[n];

`ifdef JT6295_DECIM_ROUND_EN
    localparam logic [CALCW:0] HALF = (CALCW+1)'(1) << (SHIFT-1);

    logic [CALCW:0] rnd;
    logic [OUTW:0]  shf;
    logic           unused_lsb;

    assign rnd        = {c2[CALCW-1], c2} + HALF;
    assign shf        = rnd[CALCW -: OUTW+1];
    assign unused_lsb = ^rnd[SHIFT-1:0];

    // Clamp when the extra guard bit disagrees with the output sign bit.
    always_comb begin
        out_next = shf[OUTW-1:0];
        if (shf[OUTW] != shf[OUTW-1])
            out_next = {shf[OUTW], {(OUTW-1){~shf[OUTW]}}};
    end
`else
    logic unused_lsb;

    assign out_next   = c2[CALCW-1 -: OUTW];
    assign unused_lsb = ^c2[SHIFT-1:0];
`endif

    // Output register and one-clk sample strobe.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dout <= '0;
            smp  <= 1'b0;
        end else begin
            smp <= strobe;
            if (strobe) dout <= out_next;
        end
    end

    assign bus.sound_out = dout;
    assign bus.sample    = smp;
endmodule

// File: doc/jt6295_decim.md
# jt6295_decim

Two-stage CIC decimator that converts a 14-bit mixed sample stream from the fast `cen4` rate down to the slow `cen` rate (ratio 4). It is the down-rate counterpart of the channel accumulator/interpolator. It sits between any `cen4`-rate audio source (test generators, resampled external audio) and `cen`-rate consumers in the JT6295 path. DC gain is exactly 1, and the output is registered with a sample strobe.

## Interface
- `INW`, 14: input sample width (signed).
- `OUTW`, 14: output sample width (signed); must be ≤ `INW`.
- `rate`, 4: decimation ratio R; fixed at 4 (power of two required).
- `m`, 4: comb differential delay M, in output samples.
- `n`, 2: number of integrator/comb stages N.
- `clk` input 1: system clock.
- `rst` input 1: asynchronous, active-high reset.
- `cen4` input 1: fast-rate clock enable (input sample rate).
- `cen` input 1: slow-rate clock enable; honoured only when `cen4` is also high in the same cycle.
- `sound_in` input `INW`: signed sample, sampled on `cen4`.
- `sound_out` output `OUTW`: signed decimated sample; reset value 0.
- `sample` output 1: one-clk pulse when `sound_out` updates; reset value 0.

## Operation
- Internal width CALCW = INW + N·log2(R·M) = 22; all integrator and comb arithmetic is modulo 2^CALCW (wrap is intentional and harmless).
- Integrators, on `cen4`: i1 ← i1 + sext(`sound_in`); i2 ← i2 + i1 (i2 uses the i1 value from before the update).
- Decimation, on `cen`&`cen4`: x ← i2 (pre-update value).
- Combs, on the same strobe, run as a chain across consecutive decimated strobes:
  - c1 ← x − x delayed by M strobes.
  - c2 ← c1 − c1 delayed by M strobes.
  - Each stage holds M-deep delay lines, shifted only on the strobe.
- Output, on the strobe after c2 updates: `sound_out` ← c2[CALCW−1 : CALCW−OUTW] (truncation, arithmetic shift by 8).
  - `sample` pulses high for one clk in that cycle.
- `cen` asserted without `cen4` is ignored: no state changes and no `sample` pulse.
- `cen4` without `cen` runs the integrators only.
- Reset, at any time: all integrators, delay lines, c1/c2, `sound_out` and `sample` clear to 0 asynchronously. Operation restarts on the next `cen4`, and the history is not preserved.
- No internal rate counter: decimation phase is defined purely by `cen`.

## Timing
- Input-to-integrator: 1 `cen4`. i2 reflects an input two `cen4` strobes after it is sampled.
- Pipeline registers x → c1 → c2 → `sound_out`, each advancing on one decimated strobe.
  - A decimated value appears on `sound_out` 3 strobes after capture into x.
- Impulse response spans N·(R·M−1)+1 = 31 input samples. A step input settles within 12 `cen` strobes of its first `cen4`.
- `sound_out` holds its value between strobes.
- `sample` is high only on the strobe cycle plus register delay: exactly the cycle following the clk edge that loads `sound_out`.

## Configuration
- `JT6295_DECIM_ROUND_EN`:
  - Defined: add 2^(CALCW−OUTW−1) before the shift (round half up), then saturate to [−2^(OUTW−1), 2^(OUTW−1)−1].
  - Undefined: plain truncation, no saturation logic.
- Integrator/comb behaviour is identical in both builds.

## Structure
- `jt6295_pkg`: CALCW derivation function (clog2-based), default R/M/N, and the output shift amount constant.
- Sub-module `jt6295_decim_comb`: one comb stage (M-deep delay line plus subtract, enable input), instantiated N times. Integrators stay inline.

## Test plan
- Reset: assert `rst` mid-stream with `sound_in`=5000 → `sound_out`=0 and `sample`=0 immediately. After release and 12 strobes of input 0, `sound_out` stays 0.
- DC: `sound_in`=1000 constant, `cen` every 4th `cen4` → `sound_out`==1000 from the 12th strobe onward; `sample` pulses once per `cen`.
- Negative full scale: `sound_in`=−8192 constant → settles at exactly −8192. In the `JT6295_DECIM_ROUND_EN` build, +8191 settles at 8191 (saturated, no wrap).
- Impulse: single `sound_in`=256 for one `cen4`, else 0 → nonzero `sound_out` values are ≤16 and sum to exactly 64, then return to 0.
- Enable rules: pulse `cen` on cycles without `cen4` → no `sample` and no output change. `cen4` continuous with `cen` stuck low → `sound_out` frozen.
- Long run: 10^6 `cen4` of ±8191 alternating every 8 samples → no output glitch beyond ±8192, confirming integrator wrap correctness.
